// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// The result is computed at start, held in a pending register, and committed to HI/LO when the countdown expires.
module mult_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        we,
    input  logic        hilo_sel,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [63:0]      pending_reg, pending_next;
    logic             commit_reg, commit_next;
    logic [31:0]      hi_reg, hi_next;
    logic [31:0]      lo_reg, lo_next;

    logic        signed_op, a_neg, b_neg, div_zero;
    logic [31:0] a_mag, b_mag, div_den, uq, ur, q_res, r_res;
    logic [63:0] prod_mag, prod, result;

    // Sign-magnitude datapath shared by multiply and divide; the magnitude of
    // 0x80000000 is still 0x80000000 as an unsigned value, so no overflow case is needed.
    always_comb begin
        signed_op = ~op[0];
        a_neg     = signed_op & A[31];
        b_neg     = signed_op & B[31];
        a_mag     = a_neg ? -A : A;
        b_mag     = b_neg ? -B : B;
        prod_mag  = {32'b0, a_mag} * {32'b0, b_mag};
        prod      = (a_neg ^ b_neg) ? -prod_mag : prod_mag;
        div_zero  = (B == 32'b0);
        div_den   = div_zero ? 32'd1 : b_mag;
        uq        = a_mag / div_den;
        ur        = a_mag % div_den;
        q_res     = (a_neg ^ b_neg) ? -uq : uq;
        r_res     = a_neg ? -ur : ur;
        result    = op[1] ? {r_res, q_res} : prod;
    end

    assign state = (cnt_reg != '0) ? RUN : IDLE;

    always_comb begin
        cnt_next     = cnt_reg;
        pending_next = pending_reg;
        commit_next  = commit_reg;
        hi_next      = hi_reg;
        lo_next      = lo_reg;
        case (state)
            IDLE: begin
                if (start) begin
                    cnt_next     = op[1] ? DIV_LOAD : MULT_LOAD;
                    pending_next = result;
                    commit_next  = !(op[1] && div_zero);
                end else if (we) begin
                    if (hilo_sel) hi_next = A;
                    else          lo_next = A;
                end
            end
            RUN: begin
                // start/we are deliberately not looked at here
                cnt_next = cnt_reg - CNT_ONE;
                if (cnt_reg == CNT_ONE && commit_reg) begin
                    hi_next = pending_reg[63:32];
                    lo_next = pending_reg[31:0];
                end
            end
            default: cnt_next = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_reg     <= '0;
            pending_reg <= '0;
            commit_reg  <= 1'b0;
            hi_reg      <= '0;
            lo_reg      <= '0;
        end else begin
            cnt_reg     <= cnt_next;
            pending_reg <= pending_next;
            commit_reg  <= commit_next;
            hi_reg      <= hi_next;
            lo_reg      <= lo_next;
        end
    end

    assign busy = (state == RUN);
    assign HI   = hi_reg;
    assign LO   = lo_reg;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: stimulus pushes expected HI/LO and busy length,
// a negedge monitor pops and compares whenever busy falls.
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        reset, start, we, hilo_sel;
    logic [1:0]  op;
    logic [31:0] A, B;
    logic        busy;
    logic [31:0] HI, LO;

    always #5 clk = ~clk;

    mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .A(A), .B(B),
        .we(we), .hilo_sel(hilo_sel), .busy(busy), .HI(HI), .LO(LO)
    );

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cycles;
    } exp_t;

    exp_t        scoreboard[$];
    int          checks   = 0;
    int          failures = 0;
    logic [31:0] model_hi = 32'h0;
    logic [31:0] model_lo = 32'h0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
        end
    endfunction

    // Reference: plain 64-bit integer arithmetic on the architectural values.
    function automatic logic [63:0] ref_result(input logic [1:0] o, input logic [31:0] a,
                                               input logic [31:0] b, input logic [31:0] hi,
                                               input logic [31:0] lo);
        longint x, y, p, q, r;
        if (o[0] == 1'b0) begin
            x = longint'($signed(a));
            y = longint'($signed(b));
        end else begin
            x = longint'({32'b0, a});
            y = longint'({32'b0, b});
        end
        if (o[1] == 1'b0) begin
            p = x * y;
            return p;
        end
        if (b == 32'b0) return {hi, lo};
        q = x / y;
        r = x % y;
        return {r[31:0], q[31:0]};
    endfunction

    // glitch: 0 none, 1 we during busy cycle 3, 2 start during busy cycle 3, 3 we together with start
    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input int glitch);
        logic [63:0] res;
        logic [31:0] old_hi, old_lo;
        exp_t        e;
        int          k;
        old_hi = model_hi;
        old_lo = model_lo;
        res    = ref_result(o, a, b, model_hi, model_lo);
        model_hi = res[63:32];
        model_lo = res[31:0];
        e.hi = model_hi;
        e.lo = model_lo;
        e.cycles = o[1] ? 10 : 5;
        scoreboard.push_back(e);
        @(posedge clk); #1;
        start = 1'b1; op = o; A = a; B = b;
        if (glitch == 3) begin
            we = 1'b1;
            hilo_sel = 1'($urandom);
        end
        @(posedge clk); #1;
        start = 1'b0; we = 1'b0;
        op = 2'($urandom); A = $urandom; B = $urandom;
        k = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!busy) break;
            k++;
            chk("hold_hi", HI, old_hi);
            chk("hold_lo", LO, old_lo);
            if (k == 3 && glitch == 1) begin
                we = 1'b1; hilo_sel = 1'($urandom); A = 32'hDEAD;
            end else if (k == 3 && glitch == 2) begin
                start = 1'b1; op = 2'($urandom);
            end else begin
                we = 1'b0; start = 1'b0;
            end
        end
        start = 1'b0; we = 1'b0;
        chk("busy_timeout", 32'(busy), 32'd0);
        $display("op=%0d A=0x%08h B=0x%08h glitch=%0d -> HI=0x%08h LO=0x%08h busy_cycles=%0d",
                 o, a, b, glitch, HI, LO, k);
    endtask

    task automatic write_reg(input logic sel, input logic [31:0] v);
        @(posedge clk); #1;
        we = 1'b1; hilo_sel = sel; A = v;
        @(posedge clk); #1;
        we = 1'b0; A = $urandom;
        if (sel) model_hi = v;
        else     model_lo = v;
        @(negedge clk);
        chk("mt_hi", HI, model_hi);
        chk("mt_lo", LO, model_lo);
        $display("MT%s 0x%08h -> HI=0x%08h LO=0x%08h", sel ? "HI" : "LO", v, HI, LO);
    endtask

    // Monitor: a falling busy edge outside reset is a commit to be checked.
    initial begin
        logic prev_busy;
        int   run_len;
        exp_t e;
        prev_busy = 1'b0;
        run_len   = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                run_len   = 0;
                prev_busy = 1'b0;
            end else begin
                if (busy) begin
                    run_len++;
                end else if (prev_busy) begin
                    if (scoreboard.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_commit actual=HI 0x%08h LO 0x%08h required=no commit", HI, LO);
                    end else begin
                        e = scoreboard.pop_front();
                        chk("commit_hi", HI, e.hi);
                        chk("commit_lo", LO, e.lo);
                        chk("busy_len", 32'(run_len), 32'(e.cycles));
                    end
                    run_len = 0;
                end
                prev_busy = busy;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    logic [31:0] specials [6];

    initial begin
        logic [31:0] a, b;
        logic [1:0]  o;
        specials = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'h2};
        reset = 1'b1; start = 1'b0; we = 1'b0; hilo_sel = 1'b0;
        op = 2'b00; A = 32'h0; B = 32'h0;
        #12;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_hi", HI, 32'h0);
        chk("rst_lo", LO, 32'h0);
        @(negedge clk); #2;
        reset = 1'b0;

        issue(2'b00, 32'hFFFFFFFE, 32'h3, 0);
        chk("tp_mult_hi", HI, 32'hFFFFFFFF);
        chk("tp_mult_lo", LO, 32'hFFFFFFFA);
        issue(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
        chk("tp_multu_hi", HI, 32'hFFFFFFFE);
        chk("tp_multu_lo", LO, 32'h00000001);
        issue(2'b10, 32'hFFFFFFF9, 32'h2, 0);
        chk("tp_div_hi", HI, 32'hFFFFFFFF);
        chk("tp_div_lo", LO, 32'hFFFFFFFD);
        write_reg(1'b1, 32'h11);
        write_reg(1'b0, 32'h22);
        issue(2'b11, 32'h7, 32'h0, 0);
        chk("tp_div0_hi", HI, 32'h11);
        chk("tp_div0_lo", LO, 32'h22);
        write_reg(1'b0, 32'h1234);
        chk("tp_mtlo_hi", HI, 32'h11);
        chk("tp_mtlo_lo", LO, 32'h1234);
        issue(2'b00, 32'h5, 32'h7, 1);
        chk("tp_we_busy_hi", HI, 32'h0);
        chk("tp_we_busy_lo", LO, 32'd35);
        issue(2'b10, 32'h80000000, 32'hFFFFFFFF, 2);
        chk("tp_divovf_hi", HI, 32'h0);
        chk("tp_divovf_lo", LO, 32'h80000000);
        issue(2'b00, 32'h4, 32'h9, 3);
        chk("tp_start_we_lo", LO, 32'd36);

        // Abort a divide with reset during its fourth busy cycle.
        @(posedge clk); #1;
        start = 1'b1; op = 2'b10; A = 32'd100; B = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_hi", HI, 32'h0);
        chk("abort_lo", LO, 32'h0);
        model_hi = 32'h0;
        model_lo = 32'h0;
        @(negedge clk); #2;
        reset = 1'b0;
        repeat (15) begin
            @(negedge clk);
            chk("abort_nocommit_busy", 32'(busy), 32'd0);
            chk("abort_nocommit_hi", HI, 32'h0);
            chk("abort_nocommit_lo", LO, 32'h0);
        end
        $display("reset abort -> busy=%0b HI=0x%08h LO=0x%08h", busy, HI, LO);
        issue(2'b00, 32'h2, 32'h3, 0);
        chk("tp_after_rst_hi", HI, 32'h0);
        chk("tp_after_rst_lo", LO, 32'h6);

        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 9) < 2) begin
                write_reg(1'($urandom), $urandom);
            end else begin
                o = 2'($urandom);
                a = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)] : $urandom;
                case ($urandom_range(0, 5))
                    0:       b = 32'h0;
                    1:       b = specials[$urandom_range(0, 5)];
                    2:       b = 32'($urandom_range(1, 20));
                    default: b = $urandom;
                endcase
                issue(o, a, b, int'($urandom_range(0, 3)));
            end
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 32'(scoreboard.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
